// File: rtl/f_stream_demux.sv
// f_stream_demux: registered 1-to-2 stream demux with per-channel slot and wrapping delivered-beat counters
module f_stream_demux #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              QCK,
  input  logic              QRST_N,
  input  logic              S_VALID,
  output logic              S_READY,
  input  logic [DATA_W-1:0] S_DATA,
  input  logic              S_FS,
  output logic              F1_VALID,
  input  logic              F1_READY,
  output logic [DATA_W-1:0] F1_DATA,
  output logic              F2_VALID,
  input  logic              F2_READY,
  output logic [DATA_W-1:0] F2_DATA,
  output logic [CNT_W-1:0]  F1_CNT,
  output logic [CNT_W-1:0]  F2_CNT
);
  logic [1:0]        vld, rdy, ld;
  logic              acc;
  logic [DATA_W-1:0] dat [2];
  logic [CNT_W-1:0]  cnt [2];
  assign rdy      = {F2_READY, F1_READY};
  assign S_READY  = QRST_N & (~vld[S_FS] | rdy[S_FS]);
  assign acc      = S_VALID & S_READY;
  assign ld       = {acc & S_FS, acc & ~S_FS};
  assign F1_VALID = vld[0];
  assign F2_VALID = vld[1];
  assign F1_DATA  = dat[0];
  assign F2_DATA  = dat[1];
  assign F1_CNT   = cnt[0];
  assign F2_CNT   = cnt[1];
  always_ff @(posedge QCK or negedge QRST_N)
    if (!QRST_N) begin
      vld <= '0;
      for (int k = 0; k < 2; k++) begin
        dat[k] <= '0;
        cnt[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        vld[k] <= ld[k] | (vld[k] & ~rdy[k]);
        if (ld[k]) dat[k] <= S_DATA;
        if (vld[k] & rdy[k]) cnt[k] <= cnt[k] + CNT_W'(1);
      end
    end
endmodule

// File: tb/tb_f_stream_demux.sv
// tb_f_stream_demux: queue-model self-checking bench for f_stream_demux
module tb_f_stream_demux;
  localparam int DW = 8;
  localparam int CW = 4;
  logic          clk = 0;
  logic          rst_n;
  logic          s_valid = 0, s_fs = 0, f1_ready = 0, f2_ready = 0;
  logic [DW-1:0] s_data = 0;
  logic          s_ready, f1_valid, f2_valid;
  logic [DW-1:0] f1_data, f2_data;
  logic [CW-1:0] f1_cnt, f2_cnt;
  int            passed = 0, total = 0;
  logic [DW-1:0] q1 [$], q2 [$];
  logic [DW-1:0] l1 = 0, l2 = 0;
  int            n1 = 0, n2 = 0;
  f_stream_demux #(.DATA_W(DW), .CNT_W(CW)) dut (
    .QCK(clk), .QRST_N(rst_n), .S_VALID(s_valid), .S_READY(s_ready),
    .S_DATA(s_data), .S_FS(s_fs),
    .F1_VALID(f1_valid), .F1_READY(f1_ready), .F1_DATA(f1_data),
    .F2_VALID(f2_valid), .F2_READY(f2_ready), .F2_DATA(f2_data),
    .F1_CNT(f1_cnt), .F2_CNT(f2_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else passed++;
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  function automatic logic exp_ready();
    return rst_n && (s_fs ? (q2.size() == 0 || f2_ready) : (q1.size() == 0 || f1_ready));
  endfunction
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q1.delete(); q2.delete();
      l1 = 0; l2 = 0; n1 = 0; n2 = 0;
    end else begin
      logic acc;
      acc = s_valid && exp_ready();
      if (q1.size() > 0 && f1_ready) begin void'(q1.pop_front()); n1++; end
      if (q2.size() > 0 && f2_ready) begin void'(q2.pop_front()); n2++; end
      if (acc && s_fs) begin q2.push_back(s_data); l2 = s_data; end
      if (acc && !s_fs) begin q1.push_back(s_data); l1 = s_data; end
    end
  end
  always @(negedge clk) begin
    chk("s_ready", s_ready, exp_ready());
    chk("f1_valid", f1_valid, q1.size() != 0);
    chk("f2_valid", f2_valid, q2.size() != 0);
    chk("f1_data", f1_data, q1.size() != 0 ? q1[0] : l1);
    chk("f2_data", f2_data, q2.size() != 0 ? q2[0] : l2);
    chk("f1_cnt", f1_cnt, n1 % 16);
    chk("f2_cnt", f2_cnt, n2 % 16);
  end
  task automatic send(input logic fs, input logic [DW-1:0] d);
    s_valid = 1; s_fs = fs; s_data = d;
  endtask
  initial begin
    rst_n = 0;
    s_valid = 1; f1_ready = 1; f2_ready = 1;
    repeat (3) step;
    chk("rst_s_ready", s_ready, 0);
    chk("rst_f1_valid", f1_valid, 0);
    chk("rst_f2_valid", f2_valid, 0);
    chk("rst_cnts", {f1_cnt, f2_cnt}, 0);
    s_valid = 0;
    rst_n = 1;
    send(0, 8'hA5);
    step;
    chk("steer_f1_data", f1_data, 8'hA5);
    chk("steer_f1_valid", f1_valid, 1);
    send(1, 8'h3C);
    step;
    chk("steer_f2_data", f2_data, 8'h3C);
    s_valid = 0;
    step;
    chk("steer_f1_cnt", f1_cnt, 1);
    chk("steer_f2_cnt", f2_cnt, 1);
    f1_ready = 0;
    send(0, 8'h11);
    step;
    send(0, 8'h22);
    #1;
    chk("bp_s_ready_low", s_ready, 0);
    step;
    chk("bp_hold_data", f1_data, 8'h11);
    chk("bp_still_blocked", s_ready, 0);
    f1_ready = 1;
    #1;
    chk("bp_s_ready_high", s_ready, 1);
    step;
    chk("bp_reload_data", f1_data, 8'h22);
    chk("bp_reload_valid", f1_valid, 1);
    chk("bp_cnt", f1_cnt, 2);
    s_valid = 0;
    step;
    chk("bp_drained", f1_valid, 0);
    f1_ready = 0;
    send(0, 8'h55);
    step;
    send(1, 8'h77);
    #1;
    chk("hol_other_ok", s_ready, 1);
    step;
    chk("hol_f2_data", f2_data, 8'h77);
    send(0, 8'h66);
    #1;
    chk("hol_blocked", s_ready, 0);
    step;
    chk("hol_f1_hold", f1_data, 8'h55);
    f1_ready = 1;
    step;
    chk("hol_f1_reload", f1_data, 8'h66);
    s_valid = 0;
    step;
    f1_ready = 0; f2_ready = 0;
    send(0, 8'h81);
    step;
    send(1, 8'h82);
    step;
    s_valid = 0;
    chk("mid_both_full", {f1_valid, f2_valid}, 2'b11);
    #2;
    rst_n = 0;
    #1;
    chk("async_f1_valid", f1_valid, 0);
    chk("async_f2_valid", f2_valid, 0);
    chk("async_s_ready", s_ready, 0);
    step;
    rst_n = 1;
    f1_ready = 1; f2_ready = 1;
    for (int i = 0; i < 100; i++) begin
      send(i[0], DW'(i));
      #1;
      chk("tput_s_ready", s_ready, 1);
      step;
    end
    s_valid = 0;
    step;
    chk("tput_f1_cnt", f1_cnt, 50 % 16);
    chk("tput_f2_cnt", f2_cnt, 50 % 16);
    rst_n = 0;
    step;
    rst_n = 1;
    for (int i = 0; i < 17; i++) begin
      send(1, DW'(8'hC0 + i));
      step;
    end
    s_valid = 0;
    step;
    chk("wrap_f2_cnt", f2_cnt, 1);
    chk("wrap_f1_cnt", f1_cnt, 0);
    for (int i = 0; i < 3000; i++) begin
      s_valid  = 1'($urandom_range(0, 1));
      s_fs     = 1'($urandom_range(0, 1));
      s_data   = DW'($urandom);
      f1_ready = ($urandom_range(0, 3) != 0);
      f2_ready = ($urandom_range(0, 2) == 0);
      step;
    end
    s_valid = 0;
    step;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
